cr_cceip_64_support_df_demux: RTL

Single-input, dual-output AXI4-Stream steering block for the 64-bit CCEIP support datapath. It splits one inbound stream into two outbound streams, one toward each CRC/CG lane. The destination is latched per frame: a select change never splits a frame. One registered output slot gives a fixed one-cycle latency. Per-destination frame counters and an idle flag feed supervisor status.

---
 rtl/cr_cceip_64_support_df_demux.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/cr_cceip_64_support_df_demux.sv
// ---------------------------------------------------------------------------
// cr_cceip_64_support_df_demux
//
// Steers one inbound AXI4-Stream onto one of two outbound streams (one per
// CRC/CG lane). The destination is chosen once per frame, when the first
// beat of the frame is accepted, so a select change can never split a frame.
// A single registered output slot gives a fixed one-cycle latency while still
// allowing a full rate of one beat per cycle.
//
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   df_demux_sel      requested destination for the next frame (0=ob0, 1=ob1)
//   ib_*              inbound stream (tvalid/tready/tlast/tid/tstrb/tuser/tdata)
//   ob0_tvalid/tready destination 0 handshake
//   ob1_tvalid/tready destination 1 handshake
//   ob_*              outbound beat fields, shared by both destinations
//   frm_cnt0/1        frames delivered per destination (8-bit, wrapping)
//   sel_active        destination of the current or most recent frame
//   demux_idle        no frame in progress and output slot empty
// ---------------------------------------------------------------------------
module cr_cceip_64_support_df_demux #(
  parameter int DATA_W = 64,
  parameter int STRB_W = 8,
  parameter int USER_W = 8,
  parameter int ID_W   = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              df_demux_sel,

  input  logic              ib_tvalid,
  output logic              ib_tready,
  input  logic              ib_tlast,
  input  logic [ID_W-1:0]   ib_tid,
  input  logic [STRB_W-1:0] ib_tstrb,
  input  logic [USER_W-1:0] ib_tuser,
  input  logic [DATA_W-1:0] ib_tdata,

  output logic              ob0_tvalid,
  input  logic              ob0_tready,
  output logic              ob1_tvalid,
  input  logic              ob1_tready,
  output logic              ob_tlast,
  output logic [ID_W-1:0]   ob_tid,
  output logic [STRB_W-1:0] ob_tstrb,
  output logic [USER_W-1:0] ob_tuser,
  output logic [DATA_W-1:0] ob_tdata,

  output logic [7:0]        frm_cnt0,
  output logic [7:0]        frm_cnt1,
  output logic              sel_active,
  output logic              demux_idle
);

  typedef enum logic {
    IDLE    = 1'b0,
    INFRAME = 1'b1
  } state_t;

  state_t state;
  state_t state_nxt;

  // Output slot: valid flag and destination tag; beat fields live directly
  // in the ob_* output registers.
  logic sv;
  logic dst;
  logic sv_nxt;

  logic acc;
  logic drn;
  logic beat_dst;

  // Drain only looks at the ready of the destination the slot is tagged
  // with, so the other lane's ready can never release or stall the slot.
  assign drn = sv & (dst ? ob1_tready : ob0_tready);

  // Combinational ready lets a new beat enter in the same cycle the slot
  // drains, which is what sustains one beat per cycle.
  assign ib_tready = ~rst & (~sv | drn);
  assign acc       = ib_tvalid & ib_tready;

  // First beat of a frame takes the live select; later beats follow the
  // select latched at frame start.
  assign beat_dst = (state == IDLE) ? df_demux_sel : sel_active;

  assign ob0_tvalid = sv & ~dst;
  assign ob1_tvalid = sv & dst;

  always_comb begin
    state_nxt = state;
    if (acc) begin
      state_nxt = ib_tlast ? IDLE : INFRAME;
    end
  end

  always_comb begin
    sv_nxt = sv;
    if (acc) begin
      sv_nxt = 1'b1;
    end else if (drn) begin
      sv_nxt = 1'b0;
    end
  end

  // Frame FSM, output slot, and status registers. Reset discards any beat
  // held in the slot, so a partially delivered frame is never counted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      sv         <= 1'b0;
      dst        <= 1'b0;
      ob_tlast   <= 1'b0;
      ob_tid     <= '0;
      ob_tstrb   <= '0;
      ob_tuser   <= '0;
      ob_tdata   <= '0;
      sel_active <= 1'b0;
      demux_idle <= 1'b1;
    end else begin
      state      <= state_nxt;
      sv         <= sv_nxt;
      demux_idle <= (state_nxt == IDLE) & ~sv_nxt;
      if (acc) begin
        dst      <= beat_dst;
        ob_tlast <= ib_tlast;
        ob_tid   <= ib_tid;
        ob_tstrb <= ib_tstrb;
        ob_tuser <= ib_tuser;
        ob_tdata <= ib_tdata;
        if (state == IDLE) begin
          sel_active <= df_demux_sel;
        end
      end
    end
  end

  // A frame counts as delivered when its tlast beat leaves the slot.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frm_cnt0 <= 8'h00;
      frm_cnt1 <= 8'h00;
    end else if (drn && ob_tlast) begin
      if (dst) begin
        frm_cnt1 <= frm_cnt1 + 8'h01;
      end else begin
        frm_cnt0 <= frm_cnt0 + 8'h01;
      end
    end
  end

endmodule
